// File: rtl/ysyx_22050019_pkg.sv
// Shared constants, control-bundle layout and EXU entry payload type for the ID/EXU boundary.
// No logic; consumed by the ID->EXU register and its hazard detector.
// No flow control.
package ysyx_22050019_pkg;

    localparam int          XLEN     = 64;
    localparam int          CTRL_W   = 16;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    // Control bundle layout: [5:0] ALU op, [8:6] mem size, [11:9] branch type, rest reserved.
    localparam int CTRL_ALU_OP_LSB   = 0;
    localparam int CTRL_ALU_OP_W     = 6;
    localparam int CTRL_MEM_SIZE_LSB = 6;
    localparam int CTRL_MEM_SIZE_W   = 3;
    localparam int CTRL_BR_TYPE_LSB  = 9;
    localparam int CTRL_BR_TYPE_W    = 3;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [31:0]       inst;
        logic [4:0]        rd;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] ctrl;
    } exu_dat_t;

    function automatic logic src_matches(input logic used, input logic [4:0] src, input logic [4:0] rd);
        return used && (src == rd);
    endfunction

endpackage

// File: rtl/ysyx_22050019_load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still sitting in EXU.
// Combinational, zero latency.
// No flow control; the caller decides whether to stall or bubble.
module ysyx_22050019_load_use_detect
    import ysyx_22050019_pkg::*;
(
    input  logic       exu_valid,
    input  logic       exu_mem_ren,
    input  logic       exu_rd_wen,
    input  logic [4:0] exu_rd,
    input  logic [4:0] rs1,
    input  logic       rs1_used,
    input  logic [4:0] rs2,
    input  logic       rs2_used,
    output logic       load_use
);

    logic producer_is_load;

    // x0 never carries a result, so a load to x0 can never create a hazard.
    assign producer_is_load = exu_valid & exu_mem_ren & exu_rd_wen & (exu_rd != REG_ZERO);
    assign load_use = producer_is_load &
                      (src_matches(rs1_used, rs1, exu_rd) | src_matches(rs2_used, rs2, exu_rd));

endmodule

// File: rtl/ysyx_22050019_id_exu_reg.sv
// ID->EXU pipeline register with load-use bubble insertion, redirect flush and bubble counter.
// Latency: one cycle ID to EXU; one instruction per cycle without hazards.
// Backpressure: holds the entry while EXU is not ready; id_ready_o low on stall or load-use.
module ysyx_22050019_id_exu_reg
    import ysyx_22050019_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [31:0]       id_inst_i,
    input  logic [4:0]        id_rs1_i,
    input  logic [4:0]        id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [4:0]        id_rd_i,
    input  logic              id_rd_wen_i,
    input  logic              id_mem_ren_i,
    input  logic [XLEN-1:0]   id_op1_i,
    input  logic [XLEN-1:0]   id_op2_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    output logic              exu_valid_o,
    input  logic              exu_ready_i,
    output logic [XLEN-1:0]   exu_pc_o,
    output logic [31:0]       exu_inst_o,
    output logic [4:0]        exu_rd_o,
    output logic [XLEN-1:0]   exu_op1_o,
    output logic [XLEN-1:0]   exu_op2_o,
    output logic [XLEN-1:0]   exu_imm_o,
    output logic [CTRL_W-1:0] exu_ctrl_o,
    output logic              exu_rd_wen_o,
    output logic              exu_mem_ren_o,
    output logic              load_use_stall_o,
    output logic [31:0]       bubble_cnt_o
);

    exu_dat_t    exu_q;
    logic        exu_valid_q;
    logic        exu_rd_wen_q;
    logic        exu_mem_ren_q;
    logic [31:0] bubble_cnt_q;
    logic        load_use;
    logic        free;

    ysyx_22050019_load_use_detect u_load_use_detect (
        .exu_valid   (exu_valid_q),
        .exu_mem_ren (exu_mem_ren_q),
        .exu_rd_wen  (exu_rd_wen_q),
        .exu_rd      (exu_q.rd),
        .rs1         (id_rs1_i),
        .rs1_used    (id_rs1_used_i),
        .rs2         (id_rs2_i),
        .rs2_used    (id_rs2_used_i),
        .load_use    (load_use)
    );

    assign free             = ~exu_valid_q | exu_ready_i;
    assign id_ready_o       = flush_i | (free & ~load_use);
    assign load_use_stall_o = load_use & id_valid_i;

    // Bubbles and flushes only clear the fields EXU and forwarding look at; the rest is don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            exu_valid_q   <= 1'b0;
            exu_rd_wen_q  <= 1'b0;
            exu_mem_ren_q <= 1'b0;
            exu_q         <= '0;
            exu_q.inst    <= NOP_INST;
            bubble_cnt_q  <= '0;
        end else if (flush_i) begin
            exu_valid_q   <= 1'b0;
            exu_rd_wen_q  <= 1'b0;
            exu_mem_ren_q <= 1'b0;
            exu_q.inst    <= NOP_INST;
        end else if (free) begin
            if (id_valid_i && !load_use) begin
                exu_valid_q   <= 1'b1;
                exu_rd_wen_q  <= id_rd_wen_i;
                exu_mem_ren_q <= id_mem_ren_i;
                exu_q.pc      <= id_pc_i;
                exu_q.inst    <= id_inst_i;
                exu_q.rd      <= id_rd_i;
                exu_q.op1     <= id_op1_i;
                exu_q.op2     <= id_op2_i;
                exu_q.imm     <= id_imm_i;
                exu_q.ctrl    <= id_ctrl_i;
            end else begin
                exu_valid_q   <= 1'b0;
                exu_rd_wen_q  <= 1'b0;
                exu_mem_ren_q <= 1'b0;
                exu_q.inst    <= NOP_INST;
                if (id_valid_i) begin
                    bubble_cnt_q <= bubble_cnt_q + 32'd1;
                end
            end
        end
    end

    assign exu_valid_o   = exu_valid_q;
    assign exu_rd_wen_o  = exu_rd_wen_q;
    assign exu_mem_ren_o = exu_mem_ren_q;
    assign exu_pc_o      = exu_q.pc;
    assign exu_inst_o    = exu_q.inst;
    assign exu_rd_o      = exu_q.rd;
    assign exu_op1_o     = exu_q.op1;
    assign exu_op2_o     = exu_q.op2;
    assign exu_imm_o     = exu_q.imm;
    assign exu_ctrl_o    = exu_q.ctrl;
    assign bubble_cnt_o  = bubble_cnt_q;

endmodule

// File: tb/tb_ysyx_22050019_id_exu_reg.sv
// Scenario tasks plus a randomized run against a rule-level model of the ID->EXU register.
// Inputs change one time unit after the rising edge; outputs are sampled away from the edge.
// The model tracks the EXU entry as plain state and applies the stage rules each cycle.
module tb_ysyx_22050019_id_exu_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, flush, id_valid, exu_ready;
    logic [63:0] id_pc, id_op1, id_op2, id_imm;
    logic [31:0] id_inst;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used, id_rd_wen, id_mem_ren;
    logic [15:0] id_ctrl;

    logic        id_ready, exu_valid, exu_rd_wen, exu_mem_ren, stall;
    logic [63:0] exu_pc, exu_op1, exu_op2, exu_imm;
    logic [31:0] exu_inst, bubble_cnt;
    logic [4:0]  exu_rd;
    logic [15:0] exu_ctrl;

    // Reference state: what EXU should currently hold.
    logic        e_valid, e_rd_wen, e_mem_ren;
    logic [63:0] e_pc, e_op1, e_op2, e_imm;
    logic [31:0] e_inst, e_cnt;
    logic [4:0]  e_rd;
    logic [15:0] e_ctrl;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_22050019_id_exu_reg dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .id_valid_i(id_valid), .id_ready_o(id_ready),
        .id_pc_i(id_pc), .id_inst_i(id_inst), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .id_rd_i(id_rd), .id_rd_wen_i(id_rd_wen), .id_mem_ren_i(id_mem_ren),
        .id_op1_i(id_op1), .id_op2_i(id_op2), .id_imm_i(id_imm), .id_ctrl_i(id_ctrl),
        .exu_valid_o(exu_valid), .exu_ready_i(exu_ready),
        .exu_pc_o(exu_pc), .exu_inst_o(exu_inst), .exu_rd_o(exu_rd),
        .exu_op1_o(exu_op1), .exu_op2_o(exu_op2), .exu_imm_o(exu_imm), .exu_ctrl_o(exu_ctrl),
        .exu_rd_wen_o(exu_rd_wen), .exu_mem_ren_o(exu_mem_ren),
        .load_use_stall_o(stall), .bubble_cnt_o(bubble_cnt)
    );

    // A load in EXU writing a real register that ID wants to read cannot be forwarded yet.
    function automatic bit m_hazard();
        bit reads_it;
        reads_it = (id_rs1_used && id_rs1 == e_rd) || (id_rs2_used && id_rs2 == e_rd);
        return e_valid && e_mem_ren && e_rd_wen && e_rd != 5'd0 && reads_it;
    endfunction

    function automatic bit m_ready();
        return flush || ((!e_valid || exu_ready) && !m_hazard());
    endfunction

    task automatic make_empty();
        e_valid = 1'b0; e_rd_wen = 1'b0; e_mem_ren = 1'b0; e_inst = NOP;
    endtask

    // Advances one clock and applies the stage rules to the model.
    task automatic tick();
        bit hz, room;
        hz   = m_hazard();
        room = !e_valid || exu_ready;
        @(posedge clk);
        if (rst) begin
            make_empty();
            e_pc = 0; e_op1 = 0; e_op2 = 0; e_imm = 0; e_rd = 0; e_ctrl = 0; e_cnt = 0;
        end else if (flush) begin
            make_empty();
        end else if (room && id_valid && !hz) begin
            e_valid = 1'b1; e_rd_wen = id_rd_wen; e_mem_ren = id_mem_ren;
            e_pc = id_pc; e_inst = id_inst; e_rd = id_rd;
            e_op1 = id_op1; e_op2 = id_op2; e_imm = id_imm; e_ctrl = id_ctrl;
        end else if (room) begin
            make_empty();
            if (id_valid) e_cnt = e_cnt + 1;
        end
        #1;
    endtask

    task automatic set_instr(input logic [63:0] pc, input logic [4:0] rd, input logic rd_wen,
                             input logic mem_ren, input logic [4:0] rs1, input logic rs1_used,
                             input logic [4:0] rs2, input logic rs2_used, input logic [63:0] op1);
        id_valid = 1'b1; id_pc = pc; id_inst = pc[31:0] ^ 32'h0A5A_0033;
        id_rd = rd; id_rd_wen = rd_wen; id_mem_ren = mem_ren;
        id_rs1 = rs1; id_rs1_used = rs1_used; id_rs2 = rs2; id_rs2_used = rs2_used;
        id_op1 = op1; id_op2 = op1 + 64'd7; id_imm = pc + 64'd3; id_ctrl = pc[15:0];
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; exu_ready = 1'b1;
        set_instr(64'h1000, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 64'd9);
        tick();
        tick();
        checks++;
        if (exu_valid !== 1'b0 || exu_rd_wen !== 1'b0 || exu_mem_ren !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got valid=%b rd_wen=%b mem_ren=%b, need 0 0 0", exu_valid, exu_rd_wen, exu_mem_ren);
        end
        checks++;
        if (exu_inst !== 32'h0000_0013 || bubble_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_inst_cnt: got inst=%h cnt=%0d, need 00000013 0", exu_inst, bubble_cnt);
        end
        checks++;
        if (exu_pc !== 64'd0 || exu_op1 !== 64'd0 || exu_rd !== 5'd0 || exu_ctrl !== 16'd0) begin
            errors++; $display("FAIL reset_payload: got pc=%h op1=%h rd=%0d ctrl=%h, need zeros", exu_pc, exu_op1, exu_rd, exu_ctrl);
        end
        checks++;
        if (id_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b need 1", id_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_pass_through();
        set_instr(64'h8000_0000, 5'd3, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 64'd5);
        exu_ready = 1'b1;
        #1;
        checks++;
        if (id_ready !== 1'b1) begin
            errors++; $display("FAIL pass_ready: got %b need 1", id_ready);
        end
        tick();
        checks++;
        if (exu_valid !== 1'b1 || exu_pc !== 64'h8000_0000 || exu_op1 !== 64'd5 || exu_rd !== 5'd3 || exu_rd_wen !== 1'b1) begin
            errors++; $display("FAIL pass_capture: got valid=%b pc=%h op1=%0d rd=%0d wen=%b, need 1 80000000 5 3 1",
                               exu_valid, exu_pc, exu_op1, exu_rd, exu_rd_wen);
        end
        checks++;
        if (exu_op2 !== 64'd12 || exu_imm !== 64'h8000_0003 || exu_inst !== (32'h8000_0000 ^ 32'h0A5A_0033)) begin
            errors++; $display("FAIL pass_payload: got op2=%h imm=%h inst=%h", exu_op2, exu_imm, exu_inst);
        end
    endtask

    task automatic test_backpressure();
        set_instr(64'h8000_0004, 5'd4, 1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 64'd11);
        exu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (id_ready !== 1'b0) begin
                errors++; $display("FAIL bp_ready cycle %0d: got %b need 0", i, id_ready);
            end
            tick();
            checks++;
            if (exu_valid !== 1'b1 || exu_pc !== 64'h8000_0000 || exu_op1 !== 64'd5 || exu_rd !== 5'd3) begin
                errors++; $display("FAIL bp_hold cycle %0d: got valid=%b pc=%h op1=%0d rd=%0d, need 1 80000000 5 3",
                                   i, exu_valid, exu_pc, exu_op1, exu_rd);
            end
        end
        exu_ready = 1'b1;
        #1;
        checks++;
        if (id_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready: got %b need 1", id_ready);
        end
        tick();
        checks++;
        if (exu_pc !== 64'h8000_0004 || exu_op1 !== 64'd11) begin
            errors++; $display("FAIL bp_release_capture: got pc=%h op1=%0d need 80000004 11", exu_pc, exu_op1);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] cnt0;
        cnt0 = e_cnt;
        set_instr(64'h100, 5'd5, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 64'd1);
        tick();
        set_instr(64'h104, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 64'd2);
        exu_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (id_ready !== 1'b0 || stall !== 1'b1) begin
                errors++; $display("FAIL lu_held cycle %0d: got ready=%b stall=%b need 0 1", i, id_ready, stall);
            end
            tick();
        end
        checks++;
        if (bubble_cnt !== cnt0 || exu_pc !== 64'h100) begin
            errors++; $display("FAIL lu_held_state: got cnt=%0d pc=%h need %0d 100", bubble_cnt, exu_pc, cnt0);
        end
        exu_ready = 1'b1;
        #1;
        checks++;
        if (id_ready !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL lu_stall: got ready=%b stall=%b need 0 1", id_ready, stall);
        end
        tick();
        checks++;
        if (exu_valid !== 1'b0 || exu_rd_wen !== 1'b0 || exu_inst !== NOP || bubble_cnt !== cnt0 + 32'd1) begin
            errors++; $display("FAIL lu_bubble: got valid=%b wen=%b inst=%h cnt=%0d need 0 0 00000013 %0d",
                               exu_valid, exu_rd_wen, exu_inst, bubble_cnt, cnt0 + 32'd1);
        end
        checks++;
        if (id_ready !== 1'b1 || stall !== 1'b0) begin
            errors++; $display("FAIL lu_after_ready: got ready=%b stall=%b need 1 0", id_ready, stall);
        end
        tick();
        checks++;
        if (exu_valid !== 1'b1 || exu_pc !== 64'h104 || bubble_cnt !== cnt0 + 32'd1) begin
            errors++; $display("FAIL lu_capture: got valid=%b pc=%h cnt=%0d need 1 104 %0d", exu_valid, exu_pc, bubble_cnt, cnt0 + 32'd1);
        end
    endtask

    task automatic test_no_false_hazard();
        logic [31:0] cnt0;
        cnt0 = e_cnt;
        exu_ready = 1'b1;
        set_instr(64'h200, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 64'd3);
        tick();
        set_instr(64'h204, 5'd7, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 64'd4);
        #1;
        checks++;
        if (id_ready !== 1'b1 || stall !== 1'b0) begin
            errors++; $display("FAIL nfh_x0: got ready=%b stall=%b need 1 0", id_ready, stall);
        end
        tick();
        set_instr(64'h208, 5'd8, 1'b1, 1'b0, 5'd1, 1'b1, 5'd7, 1'b0, 64'd6);
        #1;
        checks++;
        if (id_ready !== 1'b1 || stall !== 1'b0) begin
            errors++; $display("FAIL nfh_unused: got ready=%b stall=%b need 1 0", id_ready, stall);
        end
        tick();
        checks++;
        if (exu_valid !== 1'b1 || exu_pc !== 64'h208 || bubble_cnt !== cnt0) begin
            errors++; $display("FAIL nfh_capture: got valid=%b pc=%h cnt=%0d need 1 208 %0d", exu_valid, exu_pc, bubble_cnt, cnt0);
        end
    endtask

    task automatic test_flush();
        logic [31:0] cnt0;
        cnt0 = e_cnt;
        exu_ready = 1'b1;
        set_instr(64'h300, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 64'd8);
        tick();
        set_instr(64'h304, 5'd10, 1'b1, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 64'd9);
        flush = 1'b1;
        exu_ready = 1'b0;
        #1;
        checks++;
        if (id_ready !== 1'b1 || stall !== 1'b1) begin
            errors++; $display("FAIL flush_ready: got ready=%b stall=%b need 1 1", id_ready, stall);
        end
        tick();
        flush = 1'b0;
        exu_ready = 1'b1;
        checks++;
        if (exu_valid !== 1'b0 || exu_inst !== NOP || exu_rd_wen !== 1'b0 || exu_mem_ren !== 1'b0 || bubble_cnt !== cnt0) begin
            errors++; $display("FAIL flush_squash: got valid=%b inst=%h wen=%b ren=%b cnt=%0d need 0 00000013 0 0 %0d",
                               exu_valid, exu_inst, exu_rd_wen, exu_mem_ren, bubble_cnt, cnt0);
        end
    endtask

    task automatic test_random();
        bit hold;
        hold = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            exu_ready = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                set_instr({32'h8000_0000, $urandom}, 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                          5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                          {$urandom, $urandom});
                id_valid = ($urandom_range(0, 4) != 0);
            end
            #1;
            checks++;
            if (id_ready !== m_ready() || stall !== (m_hazard() && id_valid)) begin
                errors++; $display("FAIL rand_comb step %0d: got ready=%b stall=%b need %b %b",
                                   n, id_ready, stall, m_ready(), m_hazard() && id_valid);
            end
            hold = id_valid && !m_ready();
            tick();
            checks++;
            if ({exu_valid, exu_rd_wen, exu_mem_ren, exu_inst, bubble_cnt} !== {e_valid, e_rd_wen, e_mem_ren, e_inst, e_cnt} ||
                {exu_pc, exu_rd, exu_op1, exu_op2, exu_imm, exu_ctrl} !== {e_pc, e_rd, e_op1, e_op2, e_imm, e_ctrl}) begin
                errors++; $display("FAIL rand_state step %0d: got v=%b w=%b r=%b inst=%h cnt=%0d pc=%h rd=%0d need v=%b w=%b r=%b inst=%h cnt=%0d pc=%h rd=%0d",
                                   n, exu_valid, exu_rd_wen, exu_mem_ren, exu_inst, bubble_cnt, exu_pc, exu_rd,
                                   e_valid, e_rd_wen, e_mem_ren, e_inst, e_cnt, e_pc, e_rd);
            end
        end
        rst = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; exu_ready = 1'b1; id_valid = 1'b0;
        set_instr(64'h0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 64'd0);
        id_valid = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_pass_through();
        test_backpressure();
        test_load_use();
        test_no_false_hazard();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22050019_id_exu_reg.md
Name: ysyx_22050019_id_exu_reg

Overview:
- ID→EXU pipeline register for the 64-bit RV64 in-order core.
- Captures forwarded operands (from the forwarding unit's rs1/rs2 outputs), immediate, PC, instruction and the decoded control bundle into the EXU stage.
- Detects load-use hazards that forwarding cannot cover and inserts a one-cycle bubble.
- Implements valid/ready handshake, branch-redirect flush and a bubble-count performance counter.

Parameters:
XLEN, 64, datapath width
CTRL_W, 16, width of the decoded control bundle passed to EXU
NOP_INST, 32'h00000013, instruction word presented on bubble/flush/reset

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
flush_i  in  1  redirect: squash the EXU entry and the ID entry this cycle
id_valid_i  in  1  ID holds a decoded instruction
id_ready_o  out  1  register accepts the ID instruction this cycle
id_pc_i  in  XLEN  instruction PC
id_inst_i  in  32  instruction word
id_rs1_i  in  5  rs1 index
id_rs2_i  in  5  rs2 index
id_rs1_used_i  in  1  instruction reads rs1
id_rs2_used_i  in  1  instruction reads rs2
id_rd_i  in  5  destination index
id_rd_wen_i  in  1  instruction writes rd
id_mem_ren_i  in  1  instruction is a load
id_op1_i  in  XLEN  forwarded rs1 data
id_op2_i  in  XLEN  forwarded rs2 data
id_imm_i  in  XLEN  immediate
id_ctrl_i  in  CTRL_W  decoded control bundle
exu_valid_o  out  1  EXU entry valid
exu_ready_i  in  1  EXU consumes the entry this cycle
exu_pc_o / exu_inst_o / exu_rd_o / exu_op1_o / exu_op2_o / exu_imm_o / exu_ctrl_o  out  XLEN/32/5/XLEN/XLEN/XLEN/CTRL_W  registered payload
exu_rd_wen_o  out  1  registered rd write enable; feeds the forwarding unit's EXU write enable
exu_mem_ren_o  out  1  registered load flag
load_use_stall_o  out  1  combinational load-use hazard indication
bubble_cnt_o  out  32  count of injected load-use bubbles

Behaviour:
- Reset (sync, rst=1):
  - exu_valid_o=0, exu_rd_wen_o=0, exu_mem_ren_o=0.
  - exu_inst_o=NOP_INST; all other payload outputs 0; bubble_cnt_o=0.
  - rst overrides flush_i.
- load_use = exu_valid_o & exu_mem_ren_o & exu_rd_wen_o & (exu_rd_o!=0) & ((id_rs1_used_i & id_rs1_i==exu_rd_o) | (id_rs2_used_i & id_rs2_i==exu_rd_o)).
  - load_use_stall_o = load_use & id_valid_i.
- free = !exu_valid_o | exu_ready_i.
- id_ready_o = flush_i | (free & !load_use). The equation is identical during rst.
- Next-state priority per posedge:
  1. rst → reset values.
  2. flush_i → exu_valid=0, rd_wen=0, mem_ren=0, inst=NOP_INST. The ID instruction is dropped, never captured.
  3. free & id_valid_i & !load_use → capture all id_* payload, exu_valid=1.
  4. free & id_valid_i & load_use → bubble: exu_valid=0, rd_wen=0, mem_ren=0, inst=NOP_INST; bubble_cnt+1.
  5. free & !id_valid_i → exu_valid=0, rd_wen=0, mem_ren=0, inst=NOP_INST.
  6. otherwise (EXU stalled) → hold all state.
- Latency: one cycle ID→EXU. Throughput: one instruction per cycle when no hazard and exu_ready_i=1.
- A load held under backpressure keeps id_ready_o=0 for every cycle it is held. Exactly one bubble is injected on the cycle the load leaves. The dependent instruction is captured the following cycle, when the load is in LSU and LSU forwarding supplies data.
- Bubble payload other than inst/rd_wen/mem_ren/valid holds its previous value. It is don't-care for EXU.
- exu_rd_wen_o is 0 whenever exu_valid_o=0, so the forwarding unit never forwards from a bubble.
- bubble_cnt_o wraps modulo 2^32. It does not increment on flush, on stall-hold cycles, or when id_valid_i=0.
- ID must hold all id_* inputs stable while id_valid_i & !id_ready_o.

Decomposition:
- Shared package ysyx_22050019_pkg holds:
  - XLEN, CTRL_W, NOP_INST;
  - control-bundle field offsets (ALU op, mem size, branch type);
  - the REG_ZERO constant (5'd0).
- One combinational sub-module, ysyx_22050019_load_use_detect, computes load_use from the EXU entry and the ID source indices/used flags. It is reusable by a future LSU-stage hazard check.

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid_i=1 → exu_valid_o=0, exu_inst_o=0x00000013, exu_rd_wen_o=0, bubble_cnt_o=0.
- Pass-through: id_valid_i=1, pc=0x80000000, op1=5, rd=x3, rd_wen=1, exu_ready_i=1 → next cycle exu_valid_o=1, exu_pc_o=0x80000000, exu_op1_o=5, exu_rd_o=3; id_ready_o=1 throughout.
- Backpressure: EXU valid, exu_ready_i=0 for 3 cycles → id_ready_o=0 and all outputs stable. Release → next ID instruction captured the cycle after.
- Load-use: EXU holds ld rd=x5 (mem_ren=1); ID add with rs1=x5, rs1_used=1 → load_use_stall_o=1, id_ready_o=0. Next cycle exu_valid_o=0, exu_rd_wen_o=0, bubble_cnt_o=1. The cycle after, add is captured.
- No false hazard: ld rd=x0 with ID rs1=x0, and ld rd=x7 with ID rs2=x7 but rs2_used=0 → id_ready_o=1, no bubble, bubble_cnt_o unchanged.
- Flush: flush_i=1 with id_valid_i=1 and load_use=1 → id_ready_o=1, next cycle exu_valid_o=0, exu_inst_o=0x00000013, bubble_cnt_o unchanged.
